// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator for the CHIP-8 video path.
// Counters advance on a pixel-clock enable, so the block runs from the system clock.
module vga_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        pixelEnable,
    output logic        hsync,
    output logic        vsync,
    output logic        lineStart,
    output logic        frameStart
);
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] nextX, nextY;

    always_comb begin
        nextX = pixelX + 11'd1;
        nextY = pixelY;
        if (pixelX == H_LAST) begin
            nextX = 11'd0;
            nextY = (pixelY == V_LAST) ? 11'd0 : pixelY + 11'd1;
        end
    end

    // Derived outputs are loaded from the next position so everything stays aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixelX      <= H_LAST;
            pixelY      <= V_LAST;
            pixelEnable <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            lineStart   <= 1'b0;
            frameStart  <= 1'b0;
        end else if (ce) begin
            pixelX      <= nextX;
            pixelY      <= nextY;
            pixelEnable <= (nextX < H_ACT) && (nextY < V_ACT);
            hsync       <= (nextX >= HS_FIRST && nextX <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (nextY >= VS_FIRST && nextY <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            lineStart   <= (nextX == H_ACT) && (nextY < V_ACT);
            frameStart  <= (nextX == H_ACT) && (nextY == V_LAST);
        end else begin
            lineStart   <= 1'b0;
            frameStart  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance plus a tiny-raster instance
// so whole frames fit in a short run; both are checked against a position model.
module tb_vga_timing;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b1;
    always #5 clk = ~clk;

    logic [10:0] aX, aY, bX, bY;
    logic aEn, aHs, aVs, aLs, aFs, bEn, bHs, bVs, bLs, bFs;

    vga_timing dutA (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pixelX(aX), .pixelY(aY),
        .pixelEnable(aEn), .hsync(aHs), .vsync(aVs), .lineStart(aLs), .frameStart(aFs)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pixelX(bX), .pixelY(bY),
        .pixelEnable(bEn), .hsync(bHs), .vsync(bVs), .lineStart(bLs), .frameStart(bFs)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Raster geometry per instance: index 0 = default, 1 = tiny.
    int HA[2] = '{640, 8};
    int HF[2] = '{16, 2};
    int HS[2] = '{96, 3};
    int HB[2] = '{48, 2};
    int VA[2] = '{480, 6};
    int VF[2] = '{10, 2};
    int VS[2] = '{2, 2};
    int VB[2] = '{33, 3};
    bit POL[2] = '{1'b0, 1'b1};

    int mx[2], my[2];
    bit men[2], mhs[2], mvs[2], mls[2], mfs[2];

    task automatic modelStep(input int k, input bit r, input bit c);
        int ht, vt;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        if (!r) begin
            mx[k] = ht - 1; my[k] = vt - 1;
            men[k] = 0; mhs[k] = !POL[k]; mvs[k] = !POL[k]; mls[k] = 0; mfs[k] = 0;
        end else if (c) begin
            mx[k] = (mx[k] + 1) % ht;
            if (mx[k] == 0) my[k] = (my[k] + 1) % vt;
            men[k] = (mx[k] < HA[k]) && (my[k] < VA[k]);
            mhs[k] = (mx[k] >= HA[k] + HF[k] && mx[k] < HA[k] + HF[k] + HS[k]) ? POL[k] : !POL[k];
            mvs[k] = (my[k] >= VA[k] + VF[k] && my[k] < VA[k] + VF[k] + VS[k]) ? POL[k] : !POL[k];
            mls[k] = (mx[k] == HA[k]) && (my[k] < VA[k]);
            mfs[k] = (mx[k] == HA[k]) && (my[k] == vt - 1);
        end else begin
            mls[k] = 0; mfs[k] = 0;
        end
    endtask

    bit sRst = 1'b1, sCe = 1'b0, started = 1'b0;
    always @(posedge clk) begin
        sRst <= rst_n;
        sCe  <= ce;
    end

    // Per-cycle compare of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (!sRst) started = 1'b1;
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                modelStep(k, sRst, sCe);
                chk(k ? "B.pixelX" : "A.pixelX", k ? int'(bX) : int'(aX), mx[k]);
                chk(k ? "B.pixelY" : "A.pixelY", k ? int'(bY) : int'(aY), my[k]);
                chk(k ? "B.pixelEnable" : "A.pixelEnable", k ? int'(bEn) : int'(aEn), int'(men[k]));
                chk(k ? "B.hsync" : "A.hsync", k ? int'(bHs) : int'(aHs), int'(mhs[k]));
                chk(k ? "B.vsync" : "A.vsync", k ? int'(bVs) : int'(aVs), int'(mvs[k]));
                chk(k ? "B.lineStart" : "A.lineStart", k ? int'(bLs) : int'(aLs), int'(mls[k]));
                chk(k ? "B.frameStart" : "A.frameStart", k ? int'(bFs) : int'(aFs), int'(mfs[k]));
            end
        end
    end

    task automatic cyc(input bit c, input bit r);
        ce = c;
        rst_n = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n, cntLs, cntFs, cntVs, cntHs, cntEn;
        // Reset overrides ce.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        chk("rst.pixelX", int'(aX), 799);
        chk("rst.pixelY", int'(aY), 524);
        chk("rst.pixelEnable", int'(aEn), 0);
        chk("rst.hsync", int'(aHs), 1);
        chk("rst.vsync", int'(aVs), 1);
        chk("rst.strobes", int'(aLs) + int'(aFs), 0);

        // First ce after reset lands on (0,0); then count one full tiny frame.
        cyc(1'b1, 1'b1);
        chk("first.pixelX", int'(aX), 0);
        chk("first.pixelY", int'(aY), 0);
        chk("first.pixelEnable", int'(aEn), 1);
        cntLs = int'(bLs); cntFs = int'(bFs); cntVs = int'(bVs);
        for (int i = 1; i < 195; i++) begin
            cyc(1'b1, 1'b1);
            cntLs += int'(bLs); cntFs += int'(bFs); cntVs += int'(bVs);
        end
        chk("tiny.lineStartCount", cntLs, 6);
        chk("tiny.frameStartCount", cntFs, 1);
        chk("tiny.vsyncTicks", cntVs, 30);

        // Line wrap from (799,5) to (0,6).
        n = 0;
        while (!(aX == 11'd799 && aY == 11'd5) && n < 10000) begin cyc(1'b1, 1'b1); n++; end
        chk("wrap.reached", int'(n < 10000), 1);
        cyc(1'b1, 1'b1);
        chk("wrap.pixelX", int'(aX), 0);
        chk("wrap.pixelY", int'(aY), 6);
        cntHs = 0; cntEn = 0;
        for (int i = 0; i < 800; i++) begin
            cntHs += int'(!aHs); cntEn += int'(aEn);
            cyc(1'b1, 1'b1);
        end
        chk("line.hsyncLowTicks", cntHs, 96);
        chk("line.enableTicks", cntEn, 640);

        // ce every other clk, then a long ce=0 hold.
        for (int i = 0; i < 2000; i++) cyc(1'(i % 2), 1'b1);
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1);

        // Mid-frame reset at pixelX=300.
        n = 0;
        while (aX != 11'd300 && n < 2000) begin cyc(1'b1, 1'b1); n++; end
        chk("midrst.reached", int'(n < 2000), 1);
        cyc(1'b1, 1'b0);
        chk("midrst.pixelX", int'(aX), 799);
        chk("midrst.pixelY", int'(aY), 524);
        cyc(1'b1, 1'b1);
        chk("midrst.restartX", int'(aX), 0);
        chk("midrst.restartY", int'(aY), 0);
        chk("midrst.restartEn", int'(aEn), 1);

        // Randomized ce with rare resets.
        for (int i = 0; i < 30000; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4999) != 0));

        cyc(1'b0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
